// File: rtl/orb_pkg.sv
// Shared constants and types for the orbit-word write path.
// Default widths, frame length and the ping-pong bank type.
package orb_pkg;

  localparam int ORB_DW          = 12;
  localparam int ORB_AW          = 11;
  localparam int ORB_FRAME_WORDS = 32;

  typedef logic bank_t;

  function automatic bank_t bank_flip(input bank_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/orb_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after
// the pointer, wrapping modulo NCH.
module orb_rr_arb #(
  parameter int NCH = 2,
  localparam int PW = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt,
  output logic [PW-1:0]  o_idx,
  output logic           o_vld
);

  always_comb begin
    int          w_tmp;
    logic [PW-1:0] w_cand;
    o_gnt  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    w_tmp  = 0;
    w_cand = '0;
    for (int k = 0; k < NCH; k++) begin
      w_tmp = int'(i_ptr) + k;
      if (w_tmp >= NCH) w_tmp = w_tmp - NCH;
      w_cand = PW'(w_tmp);
      if (!o_vld && i_req[w_cand]) begin
        o_vld         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/orb_wr_sched.sv
// Write scheduler: captures packer write edges into one-entry holding
// registers and drains them round-robin onto a shared ping-pong RAM port.
module orb_wr_sched
  import orb_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int DW          = ORB_DW,
  parameter int AW          = ORB_AW,
  parameter int FRAME_WORDS = ORB_FRAME_WORDS
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en,
  input  logic [NCH-1:0]                 i_req_we,
  input  logic [NCH*DW-1:0]              i_req_data,
  input  logic [NCH*AW-1:0]              i_req_addr,
  output logic                           o_ram_we,
  output logic [AW:0]                    o_ram_addr,
  output logic [DW-1:0]                  o_ram_data,
  output logic                           o_wr_bank,
  output logic                           o_rd_bank,
  output logic                           o_frame_done,
  output logic [$clog2(FRAME_WORDS)-1:0] o_word_cnt,
  output logic [NCH-1:0]                 o_ovf,
  input  logic                           i_ovf_clr
);

  localparam int PW = $clog2(NCH);
  localparam int CW = $clog2(FRAME_WORDS);

  logic [NCH-1:0] r_prev_we;
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_ovf;
  logic [PW-1:0]  r_rr_ptr;
  logic [DW-1:0]  r_hold_data [NCH];
  logic [AW-1:0]  r_hold_addr [NCH];
  logic           r_ram_we;
  logic [AW:0]    r_ram_addr;
  logic [DW-1:0]  r_ram_data;
  bank_t          r_wr_bank;
  logic           r_frame_done;
  logic [CW-1:0]  r_word_cnt;

  logic [NCH-1:0] w_edge;
  logic [NCH-1:0] w_cap;
  logic [NCH-1:0] w_ovf_set;
  logic [NCH-1:0] w_gnt;
  logic [PW-1:0]  w_gnt_idx;
  logic           w_gnt_vld;
  logic           w_last;

  orb_rr_arb #(.NCH(NCH)) u_arb (
    .i_req (r_pend),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_vld (w_gnt_vld)
  );

  // A channel being granted this cycle frees its slot, so a same-cycle edge
  // refills it instead of overflowing.
  assign w_edge    = i_req_we & ~r_prev_we;
  assign w_cap     = w_edge & {NCH{i_en}} & (~r_pend | w_gnt);
  assign w_ovf_set = w_edge & {NCH{i_en}} & r_pend & ~w_gnt;
  assign w_last    = (r_word_cnt == CW'(FRAME_WORDS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev_we    <= '1;
      r_pend       <= '0;
      r_ovf        <= '0;
      r_rr_ptr     <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_wr_bank    <= 1'b0;
      r_frame_done <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_prev_we    <= i_req_we;
      r_pend       <= (r_pend & ~w_gnt) | w_cap;
      r_ovf        <= (i_ovf_clr ? '0 : r_ovf) | w_ovf_set;
      r_ram_we     <= w_gnt_vld;
      r_frame_done <= w_gnt_vld & w_last;
      if (w_gnt_vld) begin
        r_ram_data <= r_hold_data[w_gnt_idx];
        r_ram_addr <= {r_wr_bank, r_hold_addr[w_gnt_idx]};
        r_rr_ptr   <= (w_gnt_idx == PW'(NCH - 1)) ? '0 : w_gnt_idx + PW'(1);
        if (w_last) begin
          r_word_cnt <= '0;
          r_wr_bank  <= bank_flip(r_wr_bank);
        end else begin
          r_word_cnt <= r_word_cnt + CW'(1);
        end
      end
    end
  end

  // Holding registers carry data only; pend qualifies them.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (w_cap[i]) begin
        r_hold_data[i] <= i_req_data[i*DW +: DW];
        r_hold_addr[i] <= i_req_addr[i*AW +: AW];
      end
    end
  end

  assign o_ram_we     = r_ram_we;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_data   = r_ram_data;
  assign o_wr_bank    = r_wr_bank;
  assign o_rd_bank    = ~r_wr_bank;
  assign o_frame_done = r_frame_done;
  assign o_word_cnt   = r_word_cnt;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_orb_wr_sched.sv
// Directed bench for orb_wr_sched with three channels so that a pending
// word can be passed over long enough for a second edge to overflow it.
module tb_orb_wr_sched;

  localparam int NCH = 3;
  localparam int DW  = 12;
  localparam int AW  = 11;
  localparam int FW  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              ovf_clr;
  logic [NCH-1:0]    req_we;
  logic [NCH*DW-1:0] req_data;
  logic [NCH*AW-1:0] req_addr;
  logic              ram_we;
  logic [AW:0]       ram_addr;
  logic [DW-1:0]     ram_data;
  logic              wr_bank;
  logic              rd_bank;
  logic              frame_done;
  logic [4:0]        word_cnt;
  logic [NCH-1:0]    ovf;

  int checks = 0;
  int errors = 0;

  orb_wr_sched #(.NCH(NCH), .DW(DW), .AW(AW), .FRAME_WORDS(FW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_req_we     (req_we),
    .i_req_data   (req_data),
    .i_req_addr   (req_addr),
    .o_ram_we     (ram_we),
    .o_ram_addr   (ram_addr),
    .o_ram_data   (ram_data),
    .o_wr_bank    (wr_bank),
    .o_rd_bank    (rd_bank),
    .o_frame_done (frame_done),
    .o_word_cnt   (word_cnt),
    .o_ovf        (ovf),
    .i_ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] d, input logic [AW-1:0] a);
    req_data[ch*DW +: DW] = d;
    req_addr[ch*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_we = '0; en = 1'b1; ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ovf_clr = 1'b0; req_we = '0; req_data = '0; req_addr = '0;
    tick(); tick();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    checks++; if (ram_addr !== 12'h000) begin errors++; $display("FAIL reset_ram_addr: got %h want 000", ram_addr); end
    checks++; if (ram_data !== 12'h000) begin errors++; $display("FAIL reset_ram_data: got %h want 000", ram_data); end
    checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b1) begin errors++; $display("FAIL reset_banks: got wr=%b rd=%b want wr=0 rd=1", wr_bank, rd_bank); end
    checks++; if (frame_done !== 1'b0 || word_cnt !== 5'd0 || ovf !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got fd=%b cnt=%0d ovf=%b want 0 0 000", frame_done, word_cnt, ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_ch(0, 12'h5A8, 11'd4);
    req_we = 3'b001;
    tick();
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL single_early: got ram_we=%b want 0", ram_we); end
    tick();
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", ram_we); end
    checks++; if (ram_addr !== 12'h004 || ram_data !== 12'h5A8) begin errors++; $display("FAIL single_word: got addr=%h data=%h want 004 5A8", ram_addr, ram_data); end
    checks++; if (word_cnt !== 5'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", word_cnt); end
    req_we = 3'b000;
    tick();
    checks++; if (ram_we !== 1'b0 || ram_addr !== 12'h004) begin errors++; $display("FAIL single_idle: got we=%b addr=%h want 0 004", ram_we, ram_addr); end
  endtask

  task automatic test_contention();
    do_reset();
    set_ch(0, 12'h111, 11'h010);
    set_ch(1, 12'h222, 11'h020);
    req_we = 3'b011;
    tick();
    tick();
    req_we = 3'b000;
    checks++; if (ram_we !== 1'b1 || ram_data !== 12'h111 || ram_addr !== 12'h010) begin errors++; $display("FAIL cont_first: got we=%b data=%h addr=%h want 1 111 010", ram_we, ram_data, ram_addr); end
    tick();
    checks++; if (ram_we !== 1'b1 || ram_data !== 12'h222 || ram_addr !== 12'h020) begin errors++; $display("FAIL cont_second: got we=%b data=%h addr=%h want 1 222 020", ram_we, ram_data, ram_addr); end
    tick();
    set_ch(0, 12'h333, 11'h030);
    set_ch(1, 12'h444, 11'h040);
    req_we = 3'b011;
    tick();
    tick();
    req_we = 3'b000;
    checks++; if (ram_data !== 12'h333) begin errors++; $display("FAIL cont_wrap_first: got %h want 333", ram_data); end
    tick();
    checks++; if (ram_data !== 12'h444 || ram_we !== 1'b1) begin errors++; $display("FAIL cont_wrap_second: got data=%h we=%b want 444 1", ram_data, ram_we); end
    checks++; if (word_cnt !== 5'd4) begin errors++; $display("FAIL cont_cnt: got %0d want 4", word_cnt); end
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    set_ch(1, 12'h0AA, 11'h001);
    req_we = 3'b010;
    tick(); tick();
    req_we = 3'b000;
    tick();
    set_ch(0, 12'h100, 11'h050);
    set_ch(1, 12'h101, 11'h051);
    set_ch(2, 12'h102, 11'h052);
    req_we = 3'b111;
    tick();
    req_we = 3'b101;
    set_ch(1, 12'h1FF, 11'h07F);
    tick();
    checks++; if (ram_data !== 12'h102 || ram_addr !== 12'h052) begin errors++; $display("FAIL ovf_ch2_first: got data=%h addr=%h want 102 052", ram_data, ram_addr); end
    req_we = 3'b111;
    tick();
    checks++; if (ram_data !== 12'h100) begin errors++; $display("FAIL ovf_ch0: got %h want 100", ram_data); end
    checks++; if (ovf !== 3'b010) begin errors++; $display("FAIL ovf_set: got %b want 010", ovf); end
    tick();
    checks++; if (ram_we !== 1'b1 || ram_data !== 12'h101 || ram_addr !== 12'h051) begin errors++; $display("FAIL ovf_held_word: got we=%b data=%h addr=%h want 1 101 051", ram_we, ram_data, ram_addr); end
    tick();
    checks++; if (ram_we !== 1'b0 || ovf !== 3'b010) begin errors++; $display("FAIL ovf_dropped: got we=%b ovf=%b want 0 010", ram_we, ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL ovf_clr: got %b want 000", ovf); end
    req_we = 3'b000;
    tick();
  endtask

  task automatic test_bank_swap();
    logic [AW:0] ea;
    do_reset();
    for (int i = 0; i < FW; i++) begin
      set_ch(0, 12'h700 + DW'(i), AW'(i));
      req_we = 3'b001;
      tick();
      req_we = 3'b000;
      tick();
      ea = {1'b0, AW'(i)};
      checks++; if (ram_we !== 1'b1 || ram_addr !== ea) begin errors++; $display("FAIL swap_write%0d: got we=%b addr=%h want 1 %h", i, ram_we, ram_addr, ea); end
      checks++; if (frame_done !== (i == FW - 1)) begin errors++; $display("FAIL swap_fd%0d: got %b want %b", i, frame_done, (i == FW - 1)); end
    end
    checks++; if (word_cnt !== 5'd0) begin errors++; $display("FAIL swap_cnt: got %0d want 0", word_cnt); end
    checks++; if (wr_bank !== 1'b1 || rd_bank !== 1'b0) begin errors++; $display("FAIL swap_banks: got wr=%b rd=%b want 1 0", wr_bank, rd_bank); end
    set_ch(0, 12'hABC, 11'h055);
    req_we = 3'b001;
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL swap_fd_pulse: got %b want 0", frame_done); end
    req_we = 3'b000;
    tick();
    checks++; if (ram_addr !== 12'h855 || ram_data !== 12'hABC || word_cnt !== 5'd1) begin errors++; $display("FAIL swap_newbank: got addr=%h data=%h cnt=%0d want 855 ABC 1", ram_addr, ram_data, word_cnt); end
    tick();
  endtask

  task automatic test_reset_hold();
    int nw;
    rst = 1'b1; en = 1'b1; req_we = 3'b001;
    set_ch(0, 12'h0F0, 11'h003);
    tick(); tick();
    rst = 1'b0;
    nw = 0;
    repeat (4) begin tick(); if (ram_we === 1'b1) nw++; end
    checks++; if (nw != 0 || wr_bank !== 1'b0) begin errors++; $display("FAIL hold_nowrite: got writes=%0d bank=%b want 0 0", nw, wr_bank); end
    req_we = 3'b000;
    set_ch(0, 12'h3C3, 11'h007);
    tick();
    req_we = 3'b001;
    nw = 0;
    repeat (4) begin tick(); if (ram_we === 1'b1) nw++; end
    checks++; if (nw != 1 || ram_data !== 12'h3C3 || ram_addr !== 12'h007) begin errors++; $display("FAIL hold_rerise: got writes=%0d data=%h addr=%h want 1 3C3 007", nw, ram_data, ram_addr); end
    req_we = 3'b000;
    tick();
  endtask

  task automatic test_en_low();
    int nw;
    do_reset();
    set_ch(0, 12'h246, 11'h009);
    req_we = 3'b001;
    tick();
    en = 1'b0;
    req_we = 3'b011;
    tick();
    checks++; if (ram_we !== 1'b1 || ram_data !== 12'h246 || ram_addr !== 12'h009) begin errors++; $display("FAIL en_drain: got we=%b data=%h addr=%h want 1 246 009", ram_we, ram_data, ram_addr); end
    req_we = 3'b010;
    nw = 0;
    tick(); if (ram_we === 1'b1) nw++;
    req_we = 3'b111;
    repeat (4) begin tick(); if (ram_we === 1'b1) nw++; end
    checks++; if (nw != 0) begin errors++; $display("FAIL en_discard: got writes=%0d want 0", nw); end
    checks++; if (ovf !== 3'b000) begin errors++; $display("FAIL en_ovf: got %b want 000", ovf); end
    en = 1'b1;
    req_we = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_bank_swap();
    test_reset_hold();
    test_en_low();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
